// File: rtl/spi_byte_receiver.sv
// spi_byte_receiver: SPI mode 0 (CPOL=0, CPHA=0) slave receive front end.
//   Synchronises the SPI pins into clk, shifts MOSI into bytes, presents each
//   completed byte on out_byte and flags it by toggling byte_finished.
//   Optional MISO transmit path is compiled in when SPI_MISO_EN is defined.
// Parameters:
//   SYNC_STAGES  synchroniser depth on sclk/cs_n/mosi (legal 2..4)
//   MSB_FIRST    1: first received bit lands in out_byte[7]; 0: in out_byte[0]
// Ports:
//   clk, reset     system clock (>= 4x sclk), async active-high reset
//   en             receiver enable; low forces idle
//   spi_sclk/spi_cs_n/spi_mosi   asynchronous SPI inputs
//   spi_miso       serial out (tx shift reg while selected, else z); 0 without SPI_MISO_EN
//   tx_byte        byte to transmit next (unused without SPI_MISO_EN)
//   out_byte       last completed received byte
//   byte_finished  toggles once per completed byte
//   cs_active      synchronised, registered !spi_cs_n
module spi_byte_receiver #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          MSB_FIRST   = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       spi_sclk,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    input  logic [7:0] tx_byte,
    output logic [7:0] out_byte,
    output logic       byte_finished,
    output logic       cs_active
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_n_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_prev;

    logic              sclk_s;
    logic              cs_n_s;
    logic              mosi_s;
    logic              sclk_rise;
    logic              go;
    logic              take_bit;
    logic              last_bit;

    logic [CNT_W-1:0]  bit_cnt;
    logic [BYTE_W-1:0] shift_reg;
    logic              byte_done;

    // Input synchronisers plus one history flop on sclk for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync <= '0;
            cs_n_sync <= '1;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            cs_n_sync <= {cs_n_sync[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_n_s    = cs_n_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign go        = ~cs_n_s & en;

    // A rise is still taken in the cycle cs deasserts, so an 8th bit arriving
    // together with the deassert completes its byte before returning to IDLE.
    assign take_bit  = (state == SHIFT) & en & sclk_rise;
    assign last_bit  = take_bit & (bit_cnt == CNT_W'(BYTE_W - 1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (go)  state_next = SHIFT;
            SHIFT:   if (!go) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Receive datapath; completed byte is published one cycle after the 8th rise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt       <= '0;
            shift_reg     <= '0;
            byte_done     <= 1'b0;
            out_byte      <= '0;
            byte_finished <= 1'b0;
            cs_active     <= 1'b0;
        end else begin
            cs_active <= ~cs_n_s;
            byte_done <= last_bit;

            // Held at zero outside SHIFT so partial bytes are discarded
            if (state != SHIFT) begin
                bit_cnt <= '0;
            end else if (take_bit) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end

            if (take_bit) begin
                if (MSB_FIRST) begin
                    shift_reg <= {shift_reg[BYTE_W-2:0], mosi_s};
                end else begin
                    shift_reg <= {mosi_s, shift_reg[BYTE_W-1:1]};
                end
            end

            if (byte_done) begin
                out_byte      <= shift_reg;
                byte_finished <= ~byte_finished;
            end
        end
    end

`ifdef SPI_MISO_EN
    logic [BYTE_W-1:0] tx_reg;
    logic              tx_reload_pend;
    logic              sclk_fall;
    logic              start;

    assign sclk_fall = ~sclk_s & sclk_prev;
    assign start     = (state == IDLE) & go;

    // Transmit shift reg: loaded on SHIFT entry; after a byte completes the
    // next fall reloads instead of shifting so the next byte's first bit is
    // on the line before the following rise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_reg         <= '0;
            tx_reload_pend <= 1'b0;
        end else if (start) begin
            tx_reg         <= tx_byte;
            tx_reload_pend <= 1'b0;
        end else if (state != SHIFT) begin
            tx_reload_pend <= 1'b0;
        end else if (last_bit) begin
            tx_reload_pend <= 1'b1;
        end else if (sclk_fall) begin
            if (tx_reload_pend) begin
                tx_reg         <= tx_byte;
                tx_reload_pend <= 1'b0;
            end else if (MSB_FIRST) begin
                tx_reg <= {tx_reg[BYTE_W-2:0], 1'b0};
            end else begin
                tx_reg <= {1'b0, tx_reg[BYTE_W-1:1]};
            end
        end
    end

    assign spi_miso = cs_active ? (MSB_FIRST ? tx_reg[BYTE_W-1] : tx_reg[0]) : 1'bz;
`else
    logic unused_tx_byte;

    assign unused_tx_byte = ^tx_byte;
    assign spi_miso       = 1'b0;
`endif

endmodule

// File: tb/tb_spi_byte_receiver.sv
// Directed bench for spi_byte_receiver: table of single-byte CS windows plus
// hand-written sequences for latency, back-to-back bytes, aborts and reset.
module tb_spi_byte_receiver;

    localparam int unsigned SYNC = 2;

    logic       clk;
    logic       reset;
    logic       en;
    logic       spi_sclk;
    logic       spi_cs_n;
    logic       spi_mosi;
    wire        spi_miso;
    logic [7:0] tx_byte;
    logic [7:0] out_byte;
    logic       byte_finished;
    logic       cs_active;

    int         tests;
    int         fails;
    int         toggles;
    logic       bf_q;
    logic [7:0] miso_cap;

    spi_byte_receiver #(
        .SYNC_STAGES (SYNC),
        .MSB_FIRST   (1'b1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .en            (en),
        .spi_sclk      (spi_sclk),
        .spi_cs_n      (spi_cs_n),
        .spi_mosi      (spi_mosi),
        .spi_miso      (spi_miso),
        .tx_byte       (tx_byte),
        .out_byte      (out_byte),
        .byte_finished (byte_finished),
        .cs_active     (cs_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count byte_finished transitions, sampled away from the active edge
    initial begin
        toggles = 0;
        bf_q    = 1'b0;
    end
    always @(negedge clk) begin
        if (byte_finished !== bf_q) toggles <= toggles + 1;
        bf_q <= byte_finished;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish (time %0t, required finish)", $time);
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [7:0] data;
        logic       en;
        logic [7:0] exp_out;
        logic       exp_bf;
    } vec_t;

    vec_t vecs [5];

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic checki(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One SPI bit at clk/8: mosi set on the low phase, miso sampled just before the rise
    task automatic send_bit(input logic b);
        @(negedge clk);
        spi_mosi = b;
        repeat (3) @(negedge clk);
        miso_cap = {miso_cap[6:0], spi_miso};
        spi_sclk = 1'b1;
        repeat (4) @(negedge clk);
        spi_sclk = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] data, input int n);
        logic [7:0] d;
        d = data;
        for (int i = 0; i < n; i++) begin
            send_bit(d[7]);
            d = {d[6:0], 1'b0};
        end
    endtask

    task automatic cs_low();
        @(negedge clk);
        spi_cs_n = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (2) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // Final bit with clk count from the pin rise to the byte_finished toggle (0 = no toggle)
    task automatic last_bit_latency(input logic b, output int lat);
        logic bf0;
        @(negedge clk);
        spi_mosi = b;
        repeat (3) @(negedge clk);
        bf0      = byte_finished;
        spi_sclk = 1'b1;
        lat      = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (byte_finished !== bf0) begin
                lat = k;
                break;
            end
        end
        repeat (4) @(negedge clk);
        spi_sclk = 1'b0;
    endtask

    initial begin
        int         lat;
        int         t0;
        logic [7:0] b2b_data [4];
        logic       b2b_bf   [4];

        tests    = 0;
        fails    = 0;
        miso_cap = 8'h00;

        vecs[0] = '{data: 8'h3C, en: 1'b1, exp_out: 8'h3C, exp_bf: 1'b0};
        vecs[1] = '{data: 8'hFF, en: 1'b0, exp_out: 8'h3C, exp_bf: 1'b0};
        vecs[2] = '{data: 8'h81, en: 1'b1, exp_out: 8'h81, exp_bf: 1'b1};
        vecs[3] = '{data: 8'h00, en: 1'b1, exp_out: 8'h00, exp_bf: 1'b0};
        vecs[4] = '{data: 8'h7E, en: 1'b1, exp_out: 8'h7E, exp_bf: 1'b1};

        b2b_data[0] = 8'h01; b2b_bf[0] = 1'b0;
        b2b_data[1] = 8'h02; b2b_bf[1] = 1'b1;
        b2b_data[2] = 8'h03; b2b_bf[2] = 1'b0;
        b2b_data[3] = 8'h04; b2b_bf[3] = 1'b1;

        reset    = 1'b1;
        en       = 1'b1;
        spi_sclk = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        tx_byte  = 8'hC3;
        repeat (3) @(negedge clk);

        check8("reset out_byte", out_byte, 8'h00);
        check1("reset byte_finished", byte_finished, 1'b0);
        check1("reset cs_active", cs_active, 1'b0);
`ifdef SPI_MISO_EN
        check1("reset spi_miso", spi_miso, 1'bz);
`else
        check1("reset spi_miso", spi_miso, 1'b0);
`endif
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // First byte with latency from the 8th pin rise
        cs_low();
        check1("cs_active low", cs_active, 1'b1);
        send_bits(8'hA5, 7);
        last_bit_latency(1'b1, lat);
        checki("A5 toggle latency", lat, int'(SYNC) + 2);
        check8("A5 out_byte", out_byte, 8'hA5);
        check1("A5 byte_finished", byte_finished, 1'b1);
        cs_high();
        check1("cs_active high", cs_active, 1'b0);

        // Table: one byte per CS window, en per vector
        for (int i = 0; i < 5; i++) begin
            en = vecs[i].en;
            cs_low();
            send_bits(vecs[i].data, 8);
            cs_high();
            en = 1'b1;
            check8($sformatf("vec%0d out_byte", i), out_byte, vecs[i].exp_out);
            check1($sformatf("vec%0d byte_finished", i), byte_finished, vecs[i].exp_bf);
        end

        // Back-to-back bytes in one CS window
        t0 = toggles;
        cs_low();
        for (int i = 0; i < 4; i++) begin
            send_bits(b2b_data[i], 8);
            repeat (2) @(negedge clk);
            check8($sformatf("b2b%0d out_byte", i), out_byte, b2b_data[i]);
            check1($sformatf("b2b%0d byte_finished", i), byte_finished, b2b_bf[i]);
        end
        cs_high();
        checki("b2b toggle count", toggles - t0, 4);

        // Partial byte aborted by cs deassert
        t0 = toggles;
        cs_low();
        send_bits(8'hF8, 5);
        cs_high();
        check8("partial cs out_byte hold", out_byte, 8'h04);
        check1("partial cs byte_finished hold", byte_finished, 1'b1);
        cs_low();
        send_bits(8'h3C, 8);
        cs_high();
        check8("after abort out_byte", out_byte, 8'h3C);
        check1("after abort byte_finished", byte_finished, 1'b0);
        checki("after abort toggle count", toggles - t0, 1);

        // en drops mid-byte; edges while disabled are ignored
        cs_low();
        send_bits(8'hFF, 3);
        en = 1'b0;
        send_bits(8'hFF, 5);
        repeat (2) @(negedge clk);
        check8("en low out_byte hold", out_byte, 8'h3C);
        check1("en low byte_finished hold", byte_finished, 1'b0);
        en = 1'b1;
        repeat (4) @(negedge clk);
        send_bits(8'hC9, 8);
        repeat (2) @(negedge clk);
        check8("after en out_byte", out_byte, 8'hC9);
        check1("after en byte_finished", byte_finished, 1'b1);
        cs_high();

        // Async reset mid-byte
        cs_low();
        send_bits(8'hFF, 3);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check8("async reset out_byte", out_byte, 8'h00);
        check1("async reset byte_finished", byte_finished, 1'b0);
        check1("async reset cs_active", cs_active, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        send_bits(8'h5A, 8);
        repeat (2) @(negedge clk);
        check8("post reset out_byte", out_byte, 8'h5A);
        check1("post reset byte_finished", byte_finished, 1'b1);

        // cs deasserts in the same cycle as the 8th rise: byte still completes
        send_bits(8'h96, 7);
        @(negedge clk);
        spi_mosi = 1'b0;
        repeat (3) @(negedge clk);
        spi_sclk = 1'b1;
        spi_cs_n = 1'b1;
        repeat (8) @(negedge clk);
        spi_sclk = 1'b0;
        repeat (4) @(negedge clk);
        check8("cs same cycle out_byte", out_byte, 8'h96);
        check1("cs same cycle byte_finished", byte_finished, 1'b0);
        check1("cs same cycle cs_active", cs_active, 1'b0);

        // Exchange with tx_byte on MISO
        tx_byte  = 8'hC3;
        miso_cap = 8'h00;
        cs_low();
        send_bits(8'h00, 8);
        repeat (2) @(negedge clk);
        check8("exchange out_byte", out_byte, 8'h00);
        check1("exchange byte_finished", byte_finished, 1'b1);
`ifdef SPI_MISO_EN
        check8("miso captured", miso_cap, 8'hC3);
        cs_high();
        check1("miso idle", spi_miso, 1'bz);
`else
        check8("miso captured", miso_cap, 8'h00);
        cs_high();
        check1("miso idle", spi_miso, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
